// File: rtl/memory_pkg.sv
// Shared widths and types for the audio sample delay line.
package memory_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   fill_t;

  // Fill count saturates once every RAM entry holds a real sample.
  function automatic fill_t fill_inc(fill_t f);
    return (f == fill_t'(DEPTH)) ? f : f + 1'b1;
  endfunction

endpackage

// File: rtl/memory_sample_strobe.sv
// Synchronises the slow sample-rate clock into clkMain and emits a
// one-cycle strobe on each of its rising edges.
module sample_strobe #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = din;
    hist_d    = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/memory.sv
// Circular 4096-sample delay line: stores each strobed sample and returns
// the newest sample plus one tapped `delay` samples back.
module memory
  import memory_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic    clkMain,
  input  logic    rst_n,
  input  logic    clkSample,
  input  sample_t inData,
  input  addr_t   delay,
  output sample_t out1,
  output sample_t out2
);

  logic    strobe;
  logic    wr_en;
  addr_t   wr_ptr_q, wr_ptr_d;
  addr_t   rd_addr;
  fill_t   fill_q, fill_d;
  sample_t out1_q, out1_d;
  logic    rd_valid_q, rd_valid_d;
  sample_t rd_data_q;
  sample_t mem [DEPTH];

  sample_strobe #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe (
    .clk    (clkMain),
    .rst_n  (rst_n),
    .din    (clkSample),
    .strobe (strobe)
  );

  always_comb begin
    wr_en    = strobe & rst_n;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    out1_d   = out1_q;
    if (strobe) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      fill_d   = fill_inc(fill_q);
      out1_d   = inData;
    end
    rd_addr    = wr_ptr_q - addr_t'(1) - delay;
    // Taps older than the written history read as silence, not stale RAM.
    rd_valid_d = fill_t'(delay) < fill_q;
  end

  always_ff @(posedge clkMain) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      out1_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      out1_q     <= out1_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Block RAM: registered read, read-first on a same-address collision.
  always_ff @(posedge clkMain) begin
    if (wr_en) mem[wr_ptr_q] <= inData;
    rd_data_q <= mem[rd_addr];
  end

  assign out1 = out1_q;
  assign out2 = rd_valid_q ? rd_data_q : '0;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for the sample delay line: stimulus queues expectations
// tagged with a cycle number, a negedge monitor pops and compares them.
module tb_memory;
  import memory_pkg::*;

  logic    clkMain = 1'b0;
  logic    rst_n = 1'b0;
  logic    clkSample = 1'b0;
  sample_t inData = '0;
  addr_t   delay = '0;
  sample_t out1, out2;

  typedef struct {
    int          cyc;
    string       name;
    bit          kind;
    bit          chk1;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb [$];
  exp_t cur;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  memory #(.SYNC_STAGES(2)) dut (
    .clkMain   (clkMain),
    .rst_n     (rst_n),
    .clkSample (clkSample),
    .inData    (inData),
    .delay     (delay),
    .out1      (out1),
    .out2      (out2)
  );

  always #5 clkMain = ~clkMain;

  always @(posedge clkMain) cyc <= cyc + 1;

  always @(negedge clkMain) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.kind) begin
        n_tests++;
        if (32'(dut.fill_q) !== cur.e2) begin
          n_fail++;
          $display("FAIL %s: fill=%0d expected %0d (cycle %0d)", cur.name, dut.fill_q, cur.e2, cyc);
        end
      end else begin
        if (cur.chk1) begin
          n_tests++;
          if (32'(out1) !== cur.e1) begin
            n_fail++;
            $display("FAIL %s: out1=%0d expected %0d (cycle %0d)", cur.name, out1, cur.e1, cyc);
          end
        end
        n_tests++;
        if (32'(out2) !== cur.e2) begin
          n_fail++;
          $display("FAIL %s: out2=%0d expected %0d (cycle %0d)", cur.name, out2, cur.e2, cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkMain);
    #1;
  endtask

  task automatic expect_out(input int at, input string nm, input bit c1,
                            input int e1, input int e2);
    exp_t e;
    e.cyc = at; e.name = nm; e.kind = 1'b0; e.chk1 = c1;
    e.e1 = 32'(e1); e.e2 = 32'(e2);
    sb.push_back(e);
  endtask

  task automatic expect_fill(input int at, input string nm, input int f);
    exp_t e;
    e.cyc = at; e.name = nm; e.kind = 1'b1; e.chk1 = 1'b0;
    e.e1 = '0; e.e2 = 32'(f);
    sb.push_back(e);
  endtask

  task automatic send(input int v);
    inData    = sample_t'(v);
    clkSample = 1'b1;
    step(3);
    clkSample = 1'b0;
    step(3);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    step(n);
    rst_n = 1'b1;
  endtask

  int c0;

  initial begin
    // Reset held for 10 cycles while clkSample toggles, ending low.
    rst_n = 1'b0;
    step(1);
    for (int i = 1; i < 10; i++) begin
      clkSample = (i < 7) ? ~clkSample : 1'b0;
      step(1);
      expect_out(cyc, "reset_hold", 1'b1, 0, 0);
    end
    rst_n = 1'b1;
    step(3);
    expect_out(cyc, "reset_release", 1'b1, 0, 0);
    expect_fill(cyc, "reset_fill", 0);
    step(1);

    // Wrap: 5000 samples through a 4096 ring.
    delay = '0;
    for (int k = 1; k <= 5000; k++) send(k);
    expect_fill(cyc, "wrap_fill_sat", 4096);
    delay = addr_t'(4095);
    expect_out(cyc + 1, "wrap_d4095", 1'b1, 5000, 905);
    step(2);
    delay = '0;
    expect_out(cyc + 1, "wrap_d0", 1'b1, 5000, 5000);
    step(2);
    delay = addr_t'(4095);
    step(2);
    c0 = cyc;
    inData    = sample_t'(5001);
    clkSample = 1'b1;
    expect_out(c0 + 3, "wrap_read_first", 1'b1, 5001, 905);
    expect_out(c0 + 4, "wrap_after_write", 1'b1, 5001, 906);
    step(3);
    clkSample = 1'b0;
    step(3);

    // Fill gating against stale RAM contents, then basic taps.
    do_reset(2);
    delay = '0;
    for (int k = 1; k <= 3; k++) send(k);
    expect_out(cyc, "gate_newest", 1'b1, 3, 3);
    delay = addr_t'(3);
    expect_out(cyc + 1, "gate_d3_empty", 1'b0, 0, 0);
    step(1);
    delay = addr_t'(2);
    expect_out(cyc + 1, "gate_d2", 1'b0, 0, 1);
    step(1);
    for (int k = 4; k <= 10; k++) send(k);
    delay = '0;
    step(2);
    expect_out(cyc, "basic_d0", 1'b1, 10, 10);
    delay = addr_t'(3);
    expect_out(cyc, "basic_latency_old", 1'b0, 0, 10);
    expect_out(cyc + 1, "basic_d3", 1'b1, 10, 7);
    step(2);

    // Delay sweep, one new tap per clkMain cycle.
    do_reset(2);
    delay = '0;
    for (int k = 1; k <= 20; k++) send(k);
    for (int k = 0; k < 5; k++) begin
      delay = addr_t'(k);
      expect_out(cyc + 1, "sweep", 1'b0, 0, 20 - k);
      step(1);
    end
    step(1);

    // Mid-operation reset pulse.
    do_reset(2);
    delay = '0;
    for (int k = 1; k <= 100; k++) send(k);
    expect_out(cyc, "midop_before", 1'b1, 100, 100);
    step(1);
    do_reset(1);
    expect_out(cyc, "midop_reset", 1'b1, 0, 0);
    step(1);
    send(7);
    expect_out(cyc, "midop_first", 1'b1, 7, 7);
    delay = addr_t'(1);
    expect_out(cyc + 1, "midop_d1_empty", 1'b1, 7, 0);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
